exe_arbiter: RTL and testbench
==============================

Name: exe_arbiter

Overview:
- Two-requester round-robin scheduler that shares one execution unit (2-bit opcode, two ARG_BYTES-wide operands, registered result and 4-bit status, 1-cycle latency).
- Accepts requests over valid/ready, drives the execution unit's operand inputs from registers and captures its result/status.
- Returns a response to the granted requester over valid/ready.
- Sits between the issue logic and the execution unit; one operation in flight at a time.

Parameters:
- ARG_BYTES, 4, operand/result width in bits; must match the execution unit's ARG_BYTES.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high; one clock, sampled on the rising edge of i_clk.
- i_req_valid  in  2  bit r = requester r has a request.
- o_req_ready  out  2  bit r = request r accepted this cycle.
- i_req_oper  in  4  opcode of requester r at [2r+1:2r].
- i_req_argA  in  2*ARG_BYTES  operand A of requester r at slice r.
- i_req_argB  in  2*ARG_BYTES  operand B of requester r at slice r.
- o_rsp_valid  out  2  bit r = response for requester r present.
- i_rsp_ready  in  2  bit r = requester r takes the response.
- o_rsp_result  out  ARG_BYTES  result of the current response.
- o_rsp_status  out  4  status of the current response; bit 3 = error.
- o_exe_oper  out  2  to execution unit opcode input.
- o_exe_argA  out  ARG_BYTES  to execution unit operand A.
- o_exe_argB  out  ARG_BYTES  to execution unit operand B.
- o_exe_rsn  out  1  execution unit active-low reset, registered, = NOT i_rst delayed 1 cycle.
- i_exe_result  in  ARG_BYTES  from execution unit.
- i_exe_status  in  4  from execution unit.
- o_busy  out  1  high in any state except IDLE.
- o_err_cnt  out  8  saturating count of completed responses with status[3]=1.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE; all registered outputs 0, except o_exe_rsn=0 while reset is held.
  - last_grant=1, so requester 0 wins first.
  - Reset overrides everything. An operation in flight is abandoned: no response is issued and o_err_cnt is cleared.
- FSM, one operation in flight:
  - IDLE: if any i_req_valid, choose g. If both are valid, g = NOT last_grant; otherwise g = the valid one. o_req_ready[g]=1 combinationally, only in IDLE, only for g. At the edge, latch oper/argA/argB of g into o_exe_* and latch g; go to EXEC. If none is valid, stay; o_req_ready=0.
  - EXEC: o_exe_* stable; the execution unit samples them at the end of this cycle; go to CAPT.
  - CAPT: i_exe_result/i_exe_status are valid; register them into o_rsp_result/o_rsp_status; go to RESP.
  - RESP: o_rsp_valid[g]=1, other bit 0. On i_rsp_ready[g]=1: handshake; last_grant<=g; if o_rsp_status[3], o_err_cnt<=min(o_err_cnt+1,255); go to IDLE. Otherwise hold o_rsp_valid, o_rsp_result and o_rsp_status unchanged.
- Latency and throughput:
  - Handshake cycle t gives o_exe_* valid in t+1 and o_rsp_valid in t+3.
  - With i_rsp_ready held high, the next accept is at t+4 (1 op per 4 cycles).
  - i_rsp_ready high before o_rsp_valid is legal; the handshake then completes in the first RESP cycle.
- Holding and stability:
  - o_exe_* hold the last issued values outside EXEC/CAPT (no toggling when idle).
  - o_rsp_result/o_rsp_status hold their last values after the handshake; they are meaningful only with o_rsp_valid.
- Requester protocol: requesters keep valid and payload stable until ready. The arbiter does not check this; a request dropped before grant is simply not served.
- No opcode decoding: the opcode passes through unmodified; the status comes from the execution unit.

Test Plan:
- Reset: assert i_rst 2 cycles while in EXEC with i_req_valid=2'b01 -> in the cycle after reset all outputs are 0, o_exe_rsn=0 for one cycle then 1, and no o_rsp_valid appears. The next grant goes to requester 0.
- Single request: req0 oper=1, A=5, B=3, i_rsp_ready=2'b01 -> o_req_ready=01 in cycle 0; o_exe_oper=1, A=5, B=3 in cycle 1. In cycle 3, o_rsp_valid=01 with result/status equal to the reference model output. o_busy=0 and a new accept is possible in cycle 4.
- Contention: both requesters valid continuously, ready=11 -> grants 0,1,0,1,0, one every 4 cycles; each response is routed only to its own o_rsp_valid bit.
- Backpressure: req1 served with i_rsp_ready[1]=0 for 5 cycles while req0 stays valid -> o_rsp_valid=10, result and status stable for 6 cycles, o_req_ready=00 throughout. req0 is accepted in the cycle after the handshake.
- Error counter: model returns status[3]=1 for 300 consecutive ops -> o_err_cnt rises by 1 per handshake, saturates at 255 and stays there; an op with status[3]=0 leaves it unchanged.
- Early ready: i_rsp_ready held 11 from cycle 0 -> the handshake completes in the first RESP cycle with no extra wait.

Source files
------------

// File: rtl/exe_arbiter.sv
// Two-requester round-robin front end for a shared 1-cycle execution unit.
// One operation is in flight at a time: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
module exe_arbiter #(
  parameter int ARG_BYTES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_req_valid,
  output logic [1:0]             o_req_ready,
  input  logic [3:0]             i_req_oper,
  input  logic [2*ARG_BYTES-1:0] i_req_argA,
  input  logic [2*ARG_BYTES-1:0] i_req_argB,
  output logic [1:0]             o_rsp_valid,
  input  logic [1:0]             i_rsp_ready,
  output logic [ARG_BYTES-1:0]   o_rsp_result,
  output logic [3:0]             o_rsp_status,
  output logic [1:0]             o_exe_oper,
  output logic [ARG_BYTES-1:0]   o_exe_argA,
  output logic [ARG_BYTES-1:0]   o_exe_argB,
  output logic                   o_exe_rsn,
  input  logic [ARG_BYTES-1:0]   i_exe_result,
  input  logic [3:0]             i_exe_status,
  output logic                   o_busy,
  output logic [7:0]             o_err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic                   grant_r;
  logic                   last_grant_r;
  logic                   grant_s;
  logic                   accept_s;
  logic                   rsp_hs_s;
  logic [1:0]             req_ready_s;
  logic [1:0]             oper_sel_s;
  logic [ARG_BYTES-1:0]   arg_a_sel_s;
  logic [ARG_BYTES-1:0]   arg_b_sel_s;
  logic [1:0]             exe_oper_r;
  logic [ARG_BYTES-1:0]   exe_arg_a_r;
  logic [ARG_BYTES-1:0]   exe_arg_b_r;
  logic                   exe_rsn_r;
  logic [ARG_BYTES-1:0]   rsp_result_r;
  logic [3:0]             rsp_status_r;
  logic [7:0]             err_cnt_r;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (i_req_valid == 2'b11) begin
      grant_s = ~last_grant_r;
    end else if (i_req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s = (state_r == IDLE) && (|i_req_valid) && !i_rst;
  assign rsp_hs_s = (state_r == RESP) && i_rsp_ready[grant_r];

  // Ready is offered only to the chosen requester while idle.
  always_comb begin
    req_ready_s = 2'b00;
    if (accept_s) begin
      req_ready_s[grant_s] = 1'b1;
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign oper_sel_s  = grant_s ? i_req_oper[3:2] : i_req_oper[1:0];
  assign arg_a_sel_s = grant_s ? i_req_argA[2*ARG_BYTES-1:ARG_BYTES] : i_req_argA[ARG_BYTES-1:0];
  assign arg_b_sel_s = grant_s ? i_req_argB[2*ARG_BYTES-1:ARG_BYTES] : i_req_argB[ARG_BYTES-1:0];

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = CAPT;
      CAPT: state_s = RESP;
      RESP: begin
        if (rsp_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand, response and error-count registers; reset drops any op in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      exe_oper_r   <= 2'b00;
      exe_arg_a_r  <= '0;
      exe_arg_b_r  <= '0;
      exe_rsn_r    <= 1'b0;
      rsp_result_r <= '0;
      rsp_status_r <= 4'b0000;
      err_cnt_r    <= 8'd0;
    end else begin
      state_r   <= state_s;
      exe_rsn_r <= 1'b1;
      if (accept_s) begin
        grant_r     <= grant_s;
        exe_oper_r  <= oper_sel_s;
        exe_arg_a_r <= arg_a_sel_s;
        exe_arg_b_r <= arg_b_sel_s;
      end
      if (state_r == CAPT) begin
        rsp_result_r <= i_exe_result;
        rsp_status_r <= i_exe_status;
      end
      if (rsp_hs_s) begin
        last_grant_r <= grant_r;
        if (rsp_status_r[3] && (err_cnt_r != 8'hFF)) begin
          err_cnt_r <= err_cnt_r + 8'd1;
        end
      end
    end
  end

  assign o_req_ready  = req_ready_s;
  assign o_rsp_valid  = (state_r == RESP) ? (grant_r ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_result = rsp_result_r;
  assign o_rsp_status = rsp_status_r;
  assign o_exe_oper   = exe_oper_r;
  assign o_exe_argA   = exe_arg_a_r;
  assign o_exe_argB   = exe_arg_b_r;
  assign o_exe_rsn    = exe_rsn_r;
  assign o_busy       = (state_r != IDLE);
  assign o_err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_exe_arbiter.sv
// Directed bench for exe_arbiter with a behavioural 1-cycle execution unit.
module tb_exe_arbiter;

  localparam int AB = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [3:0]    req_oper;
  logic [2*AB-1:0] req_arg_a;
  logic [2*AB-1:0] req_arg_b;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [AB-1:0] rsp_result;
  logic [3:0]    rsp_status;
  logic [1:0]    exe_oper;
  logic [AB-1:0] exe_arg_a;
  logic [AB-1:0] exe_arg_b;
  logic          exe_rsn;
  logic [AB-1:0] exe_result;
  logic [3:0]    exe_status;
  logic          busy;
  logic [7:0]    err_cnt;
  logic          err_mode;

  int checks = 0;
  int errors = 0;

  exe_arbiter #(.ARG_BYTES(AB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_oper   (req_oper),
    .i_req_argA   (req_arg_a),
    .i_req_argB   (req_arg_b),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_status (rsp_status),
    .o_exe_oper   (exe_oper),
    .o_exe_argA   (exe_arg_a),
    .o_exe_argB   (exe_arg_b),
    .o_exe_rsn    (exe_rsn),
    .i_exe_result (exe_result),
    .i_exe_status (exe_status),
    .o_busy       (busy),
    .o_err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execution unit: 0 add, 1 sub, 2 and, 3 xor; status = {err_mode, 0, oper}.
  always @(posedge clk) begin
    if (!exe_rsn) begin
      exe_result <= 4'd0;
      exe_status <= 4'd0;
    end else begin
      case (exe_oper)
        2'd0:    exe_result <= exe_arg_a + exe_arg_b;
        2'd1:    exe_result <= exe_arg_a - exe_arg_b;
        2'd2:    exe_result <= exe_arg_a & exe_arg_b;
        default: exe_result <= exe_arg_a ^ exe_arg_b;
      endcase
      exe_status <= {err_mode, 1'b0, exe_oper};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] c_oper [2];
  logic [3:0] c_a    [2];
  logic [3:0] c_b    [2];
  logic [3:0] c_res  [2];
  logic [3:0] c_st   [2];

  initial begin
    // req0: and 6,3 -> 2 ; req1: xor 9,12 -> 5
    c_oper[0] = 2'd2; c_a[0] = 4'd6; c_b[0] = 4'd3;  c_res[0] = 4'd2; c_st[0] = 4'h2;
    c_oper[1] = 2'd3; c_a[1] = 4'd9; c_b[1] = 4'd12; c_res[1] = 4'd5; c_st[1] = 4'h3;

    rst = 1'b1; req_valid = 2'b00; req_oper = 4'h0; req_arg_a = 8'h00; req_arg_b = 8'h00;
    rsp_ready = 2'b00; err_mode = 1'b0;
    step(); step(); #1;
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_rspv",    32'(rsp_valid), 32'd0);
    chk("rst_rsn",     32'(exe_rsn),   32'd0);
    chk("rst_errcnt",  32'(err_cnt),   32'd0);
    chk("rst_rdy",     32'(req_ready), 32'd0);
    rst = 1'b0;
    step(); #1;
    chk("rsn_release", 32'(exe_rsn),   32'd1);

    // single request: sub 5,3
    req_valid = 2'b01; req_oper = 4'b0001; req_arg_a = 8'h05; req_arg_b = 8'h03; rsp_ready = 2'b01;
    #1;
    chk("sr_rdy",      32'(req_ready), 32'h1);
    step(); req_valid = 2'b00; #1;
    chk("sr_oper",     32'(exe_oper),  32'd1);
    chk("sr_a",        32'(exe_arg_a), 32'd5);
    chk("sr_b",        32'(exe_arg_b), 32'd3);
    chk("sr_busy",     32'(busy),      32'd1);
    step(); #1;
    chk("sr_c2_rspv",  32'(rsp_valid), 32'd0);
    step(); #1;
    chk("sr_rspv",     32'(rsp_valid), 32'h1);
    chk("sr_res",      32'(rsp_result), 32'd2);
    chk("sr_st",       32'(rsp_status), 32'h1);
    step(); #1;
    chk("sr_idle",     32'(busy),      32'd0);
    chk("sr_c4_rspv",  32'(rsp_valid), 32'd0);

    // reset while in EXEC
    req_valid = 2'b01; req_oper = 4'b1110; req_arg_a = 8'h96; req_arg_b = 8'hC3;
    #1;
    chk("rx_rdy",      32'(req_ready), 32'h1);
    step(); #1;
    chk("rx_exec",     32'(busy),      32'd1);
    chk("rx_oper",     32'(exe_oper),  32'd2);
    rst = 1'b1;
    step(); step();
    rst = 1'b0; req_valid = 2'b11; #1;
    chk("rx_busy",     32'(busy),       32'd0);
    chk("rx_rspv",     32'(rsp_valid),  32'd0);
    chk("rx_oper0",    32'(exe_oper),   32'd0);
    chk("rx_a0",       32'(exe_arg_a),  32'd0);
    chk("rx_b0",       32'(exe_arg_b),  32'd0);
    chk("rx_res0",     32'(rsp_result), 32'd0);
    chk("rx_st0",      32'(rsp_status), 32'd0);
    chk("rx_err0",     32'(err_cnt),    32'd0);
    chk("rx_rsn0",     32'(exe_rsn),    32'd0);
    chk("rx_grant0",   32'(req_ready),  32'h1);

    // contention with early ready: grants 0,1,0,1,0
    rsp_ready = 2'b11;
    for (int k = 0; k < 5; k++) begin
      automatic int g = k % 2;
      chk("ct_rdy",    32'(req_ready),  (g == 1) ? 32'h2 : 32'h1);
      step(); #1;
      if (k == 0) chk("ct_rsn", 32'(exe_rsn), 32'd1);
      chk("ct_oper",   32'(exe_oper),   32'(c_oper[g]));
      chk("ct_a",      32'(exe_arg_a),  32'(c_a[g]));
      chk("ct_b",      32'(exe_arg_b),  32'(c_b[g]));
      step(); #1;
      chk("ct_c2_rspv", 32'(rsp_valid), 32'd0);
      step(); #1;
      chk("ct_rspv",   32'(rsp_valid),  (g == 1) ? 32'h2 : 32'h1);
      chk("ct_res",    32'(rsp_result), 32'(c_res[g]));
      chk("ct_st",     32'(rsp_status), 32'(c_st[g]));
      step(); #1;
    end

    // backpressure on requester 1 while requester 0 waits
    rsp_ready = 2'b00;
    chk("bp_rdy",      32'(req_ready), 32'h2);
    step(); step(); step(); #1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_rspv",   32'(rsp_valid),  32'h2);
      chk("bp_res",    32'(rsp_result), 32'd5);
      chk("bp_st",     32'(rsp_status), 32'h3);
      chk("bp_rdy0",   32'(req_ready),  32'd0);
      if (i == 5) rsp_ready = 2'b10;
      step(); #1;
    end
    chk("bp_next_rdy", 32'(req_ready),  32'h1);
    chk("bp_hold_res", 32'(rsp_result), 32'd5);
    chk("bp_rspv_off", 32'(rsp_valid),  32'd0);
    step(); req_valid = 2'b00; rsp_ready = 2'b11;
    step(); step(); step(); #1;
    chk("bp_done",     32'(busy),       32'd0);

    // error counter saturation
    err_mode = 1'b1; req_valid = 2'b01;
    for (int n = 1; n <= 300; n++) begin
      step(); step(); step(); step(); #1;
      chk("ec_cnt",    32'(err_cnt), (n < 255) ? 32'(n) : 32'd255);
    end
    chk("ec_st",       32'(rsp_status), 32'hA);
    err_mode = 1'b0;
    step(); step(); step(); step(); #1;
    chk("ec_noerr_st", 32'(rsp_status), 32'h2);
    chk("ec_hold",     32'(err_cnt),    32'd255);
    req_valid = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
